// File: rtl/sequence_detector_101_pkg.sv
// Shared types for the overlapping "101" serial pattern detector.
// PATTERN is the reference the bench models the bitstream against.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_1    = 2'd1,
        S_10   = 2'd2,
        S_101  = 2'd3
    } state_t;

    localparam logic [2:0] PATTERN = 3'b101;

endpackage

// File: rtl/sequence_detector_101_if.sv
// Serial bit in, single-cycle detection flag out, plus the FSM state for observation.
// Handshake: there is no valid/ready; in_seq is consumed on every rising clk edge,
// and out_seq is a one-cycle event that is valid from each rising edge until the next one.
interface sequence_detector_101_if;
    import seq_det_pkg::*;

    logic   in_seq;
    logic   out_seq;
    state_t dbg_state;

    modport master (output in_seq, input out_seq, input dbg_state);
    modport slave  (input in_seq, output out_seq, output dbg_state);

endinterface

// File: rtl/sequence_detector_101.sv
// Moore FSM detecting "101" with overlap; the flag is a flop loaded alongside the state,
// so it is high exactly while the state is S_101 and has no path from in_seq.
module sequence_detector_101
    import seq_det_pkg::*;
(
    input logic                     clk,
    input logic                     reset,
    sequence_detector_101_if.slave  bus
);

    state_t r_state;
    logic   r_out_seq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_out_seq <= 1'b0;
        end else begin
            r_out_seq <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= bus.in_seq ? S_1 : S_IDLE;
                S_1:    r_state <= bus.in_seq ? S_1 : S_10;
                S_10: begin
                    if (bus.in_seq) begin
                        r_state   <= S_101;
                        r_out_seq <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                // The trailing 1 of a match is reused as the start of the next one.
                S_101:  r_state <= bus.in_seq ? S_1 : S_10;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_seq   = r_out_seq;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sequence_detector_101.sv
// Bench for sequence_detector_101: directed streams with hand-written flags,
// async reset checks, and a random stream checked against a 3-bit history model.
module tb_sequence_detector_101;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic reset;

    sequence_detector_101_if bus ();

    sequence_detector_101 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset block
    always #10 clk = ~clk;

    logic       exp_q[$];
    logic [2:0] r_hist;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // driver tasks
    task automatic send_bit(input logic b, input logic e);
        @(negedge clk);
        bus.in_seq = b;
        r_hist     = {r_hist[1:0], b};
        exp_q.push_back(e);
    endtask

    task automatic run_vec(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i], exps[i]);
    endtask

    // scoreboard monitor: one expected flag per driven bit, checked after the sampling edge
    initial begin
        logic e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_seq", {1'b0, bus.out_seq}, {1'b0, e});
            end
        end
    end

    initial begin
        logic b;
        reset      = 1'b0;
        bus.in_seq = 1'b0;
        r_hist     = 3'b000;

        #15;
        check("reset_out", {1'b0, bus.out_seq}, 2'b00);
        check("reset_state", bus.dbg_state, S_IDLE);
        @(negedge clk);
        reset = 1'b1;

        // basic match then overlap: 10101 flags on 3rd and 5th samples
        run_vec(16'b10101, 16'b00101, 5);
        // broken sequence from S_101: 0,0 then 1,0,1
        run_vec(16'b00101, 16'b00001, 5);
        // back to idle, then a run of ones
        run_vec(16'b00, 16'b00, 2);
        run_vec(16'b11101, 16'b00001, 5);
        // runs of zeros never flag
        run_vec(16'b0000, 16'b0000, 4);

        // async reset while out_seq is high
        run_vec(16'b101, 16'b001, 3);
        @(posedge clk);
        #5;
        reset = 1'b0;
        #1;
        check("async_out", {1'b0, bus.out_seq}, 2'b00);
        check("async_state", bus.dbg_state, S_IDLE);
        r_hist = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_seq = ~bus.in_seq;
            #1;
            check("hold_out", {1'b0, bus.out_seq}, 2'b00);
            check("hold_state", bus.dbg_state, S_IDLE);
        end
        @(negedge clk);
        reset = 1'b1;
        // no history survives reset: "01" alone must not complete "101"
        run_vec(16'b01, 16'b00, 2);
        run_vec(16'b01, 16'b01, 2);

        // random stream against the shift-register model
        for (int i = 0; i < 200; i++) begin
            b = 1'($urandom_range(0, 1));
            send_bit(b, {r_hist[1:0], b} == PATTERN);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected flags left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
